// File: rtl/inst_encode_writer_pkg.sv
// Shared definitions for the instruction encode/write path: immediate type codes and FSM states.
package inst_encode_writer_pkg;

    // Immediate encoding type codes; 3'd7 is unused and treated as illegal.
    localparam logic [2:0] TypeNoimm = 3'd0;
    localparam logic [2:0] TypeItype = 3'd1;
    localparam logic [2:0] TypeStype = 3'd2;
    localparam logic [2:0] TypeBtype = 3'd3;
    localparam logic [2:0] TypeUtype = 3'd4;
    localparam logic [2:0] TypeJtype = 3'd5;
    localparam logic [2:0] TypeZtype = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } writer_state_e;

endpackage

// File: rtl/inst_word_fifo.sv
// Synchronous FIFO with fall-through read: head is valid whenever empty is low.
module inst_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr_q];

    // Storage array; no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/inst_encode_writer.sv
// Packs instruction fields plus an immediate into RV32I words, range-checks the immediate,
// and streams legal words to instruction memory through a write/ack port.
module inst_encode_writer
    import inst_encode_writer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned FIFO_D = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic [2:0]        in_type,
    output logic              wr_en,
    input  logic              wr_ack,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              err,
    output logic [15:0]       err_idx,
    output logic [15:0]       wr_count
);

    // Scatter immediate bits over the base word according to the encoding type.
    function automatic logic [31:0] scatter_imm(input logic [2:0] t, input logic [31:0] imm,
                                                input logic [31:0] base);
        logic [31:0] w;
        w = base;
        case (t)
            TypeItype: w[31:20] = imm[11:0];
            TypeStype: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            TypeBtype: begin
                w[31]    = imm[12];
                w[30:25] = imm[10:5];
                w[11:8]  = imm[4:1];
                w[7]     = imm[11];
            end
            TypeUtype: w[31:12] = imm[31:12];
            TypeJtype: begin
                w[31]    = imm[20];
                w[30:21] = imm[10:1];
                w[20]    = imm[11];
                w[19:12] = imm[19:12];
            end
            TypeZtype: w[19:15] = imm[4:0];
            default: ;
        endcase
        return w;
    endfunction

    // An immediate fits when every bit above the field's sign bit matches it.
    function automatic logic imm_legal(input logic [2:0] t, input logic [31:0] imm);
        logic ok;
        case (t)
            TypeNoimm: ok = 1'b1;
            TypeItype,
            TypeStype: ok = (&imm[31:11]) | ~(|imm[31:11]);
            TypeBtype: ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            TypeUtype: ok = ~(|imm[11:0]);
            TypeJtype: ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            TypeZtype: ok = ~(|imm[31:5]);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    writer_state_e state_q;
    logic          pack_valid_q;
    logic [31:0]   pack_word_q;
    logic [15:0]   beat_count_q;

    logic          accept;
    logic          beat_legal;
    logic [31:0]   beat_word;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_head;

    assign beat_word  = scatter_imm(in_type, in_imm,
                                    {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode});
    assign beat_legal = imm_legal(in_type, in_imm);

    assign wr_en    = ~fifo_empty;
    assign wr_data  = fifo_empty ? '0 : fifo_head;
    assign pop      = wr_en & wr_ack;
    assign push     = pack_valid_q & (~fifo_full | pop);
    assign in_ready = (state_q == StRun) & (~pack_valid_q | ~fifo_full | pop);
    assign accept   = in_valid & in_ready;
    assign done     = (state_q == StDone);

    // Pack register: illegal beats are dropped here so they never reach memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_valid_q <= 1'b0;
            pack_word_q  <= '0;
        end else if (accept) begin
            pack_valid_q <= beat_legal;
            pack_word_q  <= beat_word;
        end else if (push) begin
            pack_valid_q <= 1'b0;
        end
    end

    // Session FSM plus its registered status outputs and write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_addr      <= '0;
            err          <= 1'b0;
            err_idx      <= '0;
            wr_count     <= '0;
            beat_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StRun;
                        wr_addr      <= base_addr & ~ADDR_W'(3);
                        err          <= 1'b0;
                        err_idx      <= '0;
                        wr_count     <= '0;
                        beat_count_q <= '0;
                    end
                end
                StRun: begin
                    if (accept && in_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!pack_valid_q && fifo_empty) begin
                        state_q <= StDone;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (accept) begin
                beat_count_q <= beat_count_q + 1'b1;
                if (!beat_legal && !err) begin
                    err     <= 1'b1;
                    err_idx <= beat_count_q;
                end
            end

            if (pop) begin
                wr_addr <= wr_addr + ADDR_W'(4);
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 1'b1;
                end
            end
        end
    end

    inst_word_fifo #(
        .DEPTH (FIFO_D),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pack_word_q),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
